gps_nav_tracker: RTL and testbench
==================================

GPS_NAV_TRACKER -- requirements
Module: gps_nav_tracker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of tracked channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32: signed position/velocity width.
REQ-003 SHALL have parameter JUMP_THR, default 1000: maximum legal per-sample |delta| (unsigned, DATA_W bits).
REQ-004 SHALL have parameter DEBOUNCE, default 2: consecutive over-threshold samples that raise a channel alert (1..15).
REQ-005 SHALL have port clk input 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-007 SHALL have port enable input 1: permits acceptance of new measurements.
REQ-008 SHALL have ports meas_valid input 1, meas_ready output 1: measurement handshake.
REQ-009 SHALL have ports meas_chan input clog2(NUM_CH)+1 and meas_pos input DATA_W signed: the measurement.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1: result handshake.
REQ-011 SHALL have ports out_chan output clog2(NUM_CH), position output DATA_W, velocity output DATA_W signed: the result.
REQ-012 SHALL have ports alert output 1, alert_mask output NUM_CH, alert_clr input 1, drop_cnt output 8.

Function
REQ-013 SHALL run FSM IDLE -> CALC -> CHECK -> OUT -> IDLE; meas_ready = 1 only in IDLE with enable = 1.
REQ-014 SHALL accept on meas_valid & meas_ready at cycle N; CALC at N+1, CHECK at N+2, out_valid = 1 from N+3.
REQ-015 SHALL hold out_valid and all result outputs stable in OUT until out_ready = 1, then return to IDLE on the next edge.
REQ-016 SHALL, with meas_chan >= NUM_CH, accept the measurement, drop it (no output, no state change), increment drop_cnt saturating at 255, and stay in IDLE.
REQ-017 SHALL compute the raw delta as meas_pos minus the stored last_pos[ch], modulo 2^DATA_W.
REQ-018 SHALL, on the first sample of an unprimed channel, output velocity 0, set primed[ch], and skip the jump check.
REQ-019 SHALL store meas_pos as last_pos[ch] and output it as position.
REQ-020 SHALL treat |delta| > JUMP_THR as a violation; the most-negative delta counts as a violation.
REQ-021 SHALL increment viol_cnt[ch] on a violation, saturating at DEBOUNCE, and clear it on any non-violation.
REQ-022 SHALL set alert_mask[ch] in CHECK when viol_cnt[ch] reaches DEBOUNCE; the bit is sticky.
REQ-023 SHALL clear all alert_mask bits on alert_clr = 1; when a set occurs in the same cycle, the set wins for that bit.
REQ-024 SHALL drive alert as the OR of alert_mask.
REQ-025 SHALL, when enable falls mid-transaction, complete the transaction and accept no new measurement.

Reset
REQ-026 SHALL, on rst = 1, enter IDLE and force meas_ready, out_valid, out_chan, position, velocity, alert, alert_mask and drop_cnt to 0.
REQ-027 SHALL, on rst = 1, clear all last_pos, primed, viol_cnt and filter state, including mid-transaction (the pending result is discarded).

Configuration
REQ-028 SHALL, with GPS_NAV_VEL_FILTER_EN defined, output a per-channel filtered velocity vf = vf + ((delta - vf) >>> 2), arithmetic shift; the first sample sets vf = 0.
REQ-029 SHALL, without GPS_NAV_VEL_FILTER_EN, output the raw delta and contain no filter registers.
REQ-030 SHALL use the raw delta for the jump check in both configurations.

Structure
REQ-031 SHALL place the FSM state encoding and the default parameter constants in shared package gps_nav_pkg.
REQ-032 SHALL implement the per-channel storage (last_pos, primed, viol_cnt, vf) as sub-module gps_chan_store with one read port and one write port.

Verification
REQ-033 SHALL cover: reset, then ch0 at 100 then 150 -> first out velocity 0, second velocity 50, alert 0, 3 cycles accept-to-out_valid.
REQ-034 SHALL cover: ch1 at 0, 5000, 10000 (DEBOUNCE = 2) -> alert_mask = 0b0010 after the third sample, alert = 1.
REQ-035 SHALL cover: alert_clr asserted in the same cycle as a new alert set on ch2 -> bit 2 remains set.
REQ-036 SHALL cover: meas_chan = NUM_CH -> no out_valid, drop_cnt = 1; after 300 drops, drop_cnt = 255.
REQ-037 SHALL cover: out_ready held 0 for 10 cycles -> outputs stable and meas_ready = 0 throughout.
REQ-038 SHALL cover: rst asserted in CHECK -> all outputs 0 next cycle; next ch0 sample gives velocity 0.

Source files
------------

// File: rtl/gps_nav_pkg.sv
// Shared definitions for the GPS navigation tracker: FSM state encoding and default parameters.
package gps_nav_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CHECK, S_OUT} state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_JUMP_THR = 1000;
  localparam int DEF_DEBOUNCE = 2;
  localparam int CNT_W        = 4;
endpackage

// File: rtl/gps_chan_store.sv
// Per-channel tracker state (last position, primed flag, violation count, optional filter).
// Filter storage exists only when GPS_NAV_VEL_FILTER_EN is defined.
import gps_nav_pkg::*;

module gps_chan_store #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CH_W   = $clog2(DEF_NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_last_pos,
  output logic              rd_primed,
  output logic [CNT_W-1:0]  rd_viol,
`ifdef GPS_NAV_VEL_FILTER_EN
  output logic [DATA_W-1:0] rd_vf,
  input  logic [DATA_W-1:0] wr_vf,
`endif
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_last_pos,
  input  logic [CNT_W-1:0]  wr_viol
);
  logic [DATA_W-1:0] last_pos [NUM_CH];
  logic [NUM_CH-1:0] primed;
  logic [CNT_W-1:0]  viol_cnt [NUM_CH];
`ifdef GPS_NAV_VEL_FILTER_EN
  logic [DATA_W-1:0] vf [NUM_CH];
  assign rd_vf = vf[rd_ch];
`endif

  assign rd_last_pos = last_pos[rd_ch];
  assign rd_primed   = primed[rd_ch];
  assign rd_viol     = viol_cnt[rd_ch];

  always_ff @(posedge clk) begin
    if (rst) begin
      primed <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        last_pos[i] <= '0;
        viol_cnt[i] <= '0;
`ifdef GPS_NAV_VEL_FILTER_EN
        vf[i]       <= '0;
`endif
      end
    end else if (wr_en) begin
      last_pos[wr_ch] <= wr_last_pos;
      primed[wr_ch]   <= 1'b1;
      viol_cnt[wr_ch] <= wr_viol;
`ifdef GPS_NAV_VEL_FILTER_EN
      vf[wr_ch]       <= wr_vf;
`endif
    end
  end
endmodule

// File: rtl/gps_nav_tracker.sv
// Multi-channel position tracker: velocity from successive samples, jump detection with debounced alerts.
// Define GPS_NAV_VEL_FILTER_EN to output a low-pass filtered velocity instead of the raw delta.
import gps_nav_pkg::*;

module gps_nav_tracker #(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int JUMP_THR = DEF_JUMP_THR,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       meas_valid,
  output logic                       meas_ready,
  input  logic [$clog2(NUM_CH):0]    meas_chan,
  input  logic signed [DATA_W-1:0]   meas_pos,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_CH)-1:0]  out_chan,
  output logic [DATA_W-1:0]          position,
  output logic signed [DATA_W-1:0]   velocity,
  output logic                       alert,
  output logic [NUM_CH-1:0]          alert_mask,
  input  logic                       alert_clr,
  output logic [7:0]                 drop_cnt
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [DATA_W-1:0] THR      = DATA_W'(JUMP_THR);
  localparam logic [CNT_W-1:0]  DEB      = CNT_W'(DEBOUNCE);
  localparam logic [CH_W:0]     NCH      = (CH_W+1)'(NUM_CH);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state, state_nxt;
  logic accept, chan_ok, wr_en;

  logic [CH_W-1:0]          ch_r;
  logic [DATA_W-1:0]        pos_r;
  logic signed [DATA_W-1:0] delta_r;
  logic                     first_r;
  logic [CNT_W-1:0]         vcnt_r;

  logic [DATA_W-1:0]        rd_last_pos;
  logic                     rd_primed;
  logic [CNT_W-1:0]         rd_viol;
  logic [DATA_W-1:0]        mag;
  logic                     viol;
  logic [CNT_W-1:0]         viol_new;
  logic [NUM_CH-1:0]        set_vec;
  logic signed [DATA_W-1:0] vel;

  assign chan_ok = meas_chan < NCH;
  assign wr_en   = (state == S_CHECK);
  assign alert   = |alert_mask;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    meas_ready = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        meas_ready = enable & ~rst;
        accept     = meas_valid & meas_ready;
        if (accept && chan_ok) state_nxt = S_CALC;
      end
      S_CALC:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef GPS_NAV_VEL_FILTER_EN
  logic signed [DATA_W-1:0] vf_r, rd_vf, vf_new, vf_diff;
  always_comb begin
    vf_diff = delta_r - vf_r;
    vf_new  = first_r ? '0 : vf_r + (vf_diff >>> 2);
  end
`endif

  // Jump check always uses the raw delta; the most-negative value has no representable magnitude.
  always_comb begin
    mag      = delta_r[DATA_W-1] ? -delta_r : delta_r;
    viol     = ~first_r & ((mag > THR) | (delta_r == MOST_NEG));
    viol_new = '0;
    if (viol) viol_new = (vcnt_r >= DEB) ? DEB : vcnt_r + 1'b1;
    set_vec  = '0;
    if (wr_en && viol_new == DEB) set_vec[ch_r] = 1'b1;
`ifdef GPS_NAV_VEL_FILTER_EN
    vel      = vf_new;
`else
    vel      = first_r ? '0 : delta_r;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r       <= '0;
      pos_r      <= '0;
      delta_r    <= '0;
      first_r    <= 1'b0;
      vcnt_r     <= '0;
      out_chan   <= '0;
      position   <= '0;
      velocity   <= '0;
      alert_mask <= '0;
      drop_cnt   <= '0;
`ifdef GPS_NAV_VEL_FILTER_EN
      vf_r       <= '0;
`endif
    end else begin
      if (accept && chan_ok) begin
        ch_r  <= meas_chan[CH_W-1:0];
        pos_r <= meas_pos;
      end
      if (accept && !chan_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      if (state == S_CALC) begin
        delta_r <= pos_r - rd_last_pos;
        first_r <= ~rd_primed;
        vcnt_r  <= rd_viol;
`ifdef GPS_NAV_VEL_FILTER_EN
        vf_r    <= rd_vf;
`endif
      end
      if (wr_en) begin
        out_chan <= ch_r;
        position <= pos_r;
        velocity <= vel;
      end
      // A bit being set this cycle survives a simultaneous clear.
      alert_mask <= (alert_clr ? '0 : alert_mask) | set_vec;
    end
  end

  gps_chan_store #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .rd_ch       (ch_r),
    .rd_last_pos (rd_last_pos),
    .rd_primed   (rd_primed),
    .rd_viol     (rd_viol),
`ifdef GPS_NAV_VEL_FILTER_EN
    .rd_vf       (rd_vf),
    .wr_vf       (vf_new),
`endif
    .wr_en       (wr_en),
    .wr_ch       (ch_r),
    .wr_last_pos (pos_r),
    .wr_viol     (viol_new)
  );
endmodule

// File: tb/tb_gps_nav_tracker.sv
// Directed self-checking bench for gps_nav_tracker (default build, raw-delta velocity).
module tb_gps_nav_tracker;
  logic               clk = 1'b0;
  logic               rst, enable, meas_valid, out_ready, alert_clr;
  logic [2:0]         meas_chan;
  logic signed [31:0] meas_pos;
  logic               meas_ready, out_valid, alert;
  logic [1:0]         out_chan;
  logic [31:0]        position;
  logic signed [31:0] velocity;
  logic [3:0]         alert_mask;
  logic [7:0]         drop_cnt;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  gps_nav_tracker #(
    .NUM_CH   (4),
    .DATA_W   (32),
    .JUMP_THR (1000),
    .DEBOUNCE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_chan  (meas_chan),
    .meas_pos   (meas_pos),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .position   (position),
    .velocity   (velocity),
    .alert      (alert),
    .alert_mask (alert_mask),
    .alert_clr  (alert_clr),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, latency, result, optional back-pressure hold.
  task automatic xact(input int ch, input logic [31:0] pos, input logic [31:0] exp_vel,
                      input int hold, input bit clr_in_check, input bit en_drop);
    int lat;
    logic [31:0] p0, v0, c0;
    @(negedge clk);
    for (int i = 0; i < 20 && !meas_ready; i++) @(negedge clk);
    chk("ready_before_send", meas_ready, 1);
    meas_valid = 1'b1;
    meas_chan  = 3'(ch);
    meas_pos   = pos;
    @(negedge clk);
    meas_valid = 1'b0;
    if (en_drop) enable = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      if (lat == 2 && clr_in_check) alert_clr = 1'b1;
      @(negedge clk);
      alert_clr = 1'b0;
      lat++;
    end
    chk("latency", lat, 3);
    chk("out_valid", out_valid, 1);
    chk("out_chan", out_chan, ch);
    chk("position", position, pos);
    chk("velocity", velocity, exp_vel);
    p0 = position; v0 = velocity; c0 = out_chan;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_pos", position, p0);
      chk("hold_vel", velocity, v0);
      chk("hold_chan", out_chan, c0);
      chk("hold_ready", meas_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    if (en_drop) begin
      chk("ready_disabled", meas_ready, 0);
      enable = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; meas_valid = 1'b0; out_ready = 1'b0; alert_clr = 1'b0;
    meas_chan = '0; meas_pos = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", meas_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pos", position, 0);
    chk("rst_vel", velocity, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_alert", alert, 0);
    chk("rst_mask", alert_mask, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", meas_ready, 1);

    // ch0: first sample primes, second gives delta; second held under back-pressure
    xact(0, 100, 0, 0, 0, 0);
    xact(0, 150, 50, 10, 0, 0);
    chk("ch0_alert", alert, 0);

    // ch1: two consecutive jumps raise the alert
    xact(1, 0, 0, 0, 0, 0);
    xact(1, 5000, 5000, 0, 0, 0);
    chk("ch1_mask_one_viol", alert_mask, 4'b0000);
    xact(1, 10000, 5000, 0, 0, 0);
    chk("ch1_mask", alert_mask, 4'b0010);
    chk("ch1_alert", alert, 1);

    // ch2: clear collides with a new set; set wins for bit 2, bit 1 clears
    xact(2, 0, 0, 0, 0, 0);
    xact(2, 2000, 2000, 0, 0, 0);
    xact(2, 4000, 2000, 0, 1, 0);
    chk("clr_vs_set_mask", alert_mask, 4'b0100);

    @(negedge clk); alert_clr = 1'b1;
    @(negedge clk); alert_clr = 1'b0;
    chk("clr_mask", alert_mask, 0);
    chk("clr_alert", alert, 0);

    // ch3: delta of exactly the threshold is legal, threshold+1 is not
    xact(3, 0, 0, 0, 0, 0);
    xact(3, 1000, 1000, 0, 0, 0);
    xact(3, 2001, 1001, 0, 0, 0);
    chk("thr_mask_one", alert_mask, 0);
    xact(3, 3002, 1001, 0, 0, 0);
    chk("thr_mask_two", alert_mask, 4'b1000);
    @(negedge clk); alert_clr = 1'b1;
    @(negedge clk); alert_clr = 1'b0;

    // ch0 negative delta, with enable dropped mid-transaction
    xact(0, 32'hFFFF_FFCE, 32'hFFFF_FF38, 0, 0, 1);
    chk("neg_mask", alert_mask, 0);

    // most-negative delta twice counts as two violations
    xact(0, 32'h7FFF_FFCE, 32'h8000_0000, 0, 0, 0);
    xact(0, 32'hFFFF_FFCE, 32'h8000_0000, 0, 0, 0);
    chk("minneg_mask", alert_mask, 4'b0001);

    // out-of-range channel drops
    @(negedge clk);
    meas_valid = 1'b1; meas_chan = 3'd4; meas_pos = 32'd77;
    @(negedge clk);
    meas_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drop_no_valid", out_valid, 0);
      chk("drop_ready", meas_ready, 1);
      @(negedge clk);
    end
    chk("drop_cnt_1", drop_cnt, 1);
    meas_valid = 1'b1; meas_chan = 3'd7;
    repeat (299) @(negedge clk);
    meas_valid = 1'b0;
    @(negedge clk);
    chk("drop_cnt_sat", drop_cnt, 255);
    chk("drop_mask_kept", alert_mask, 4'b0001);

    // reset while in CHECK discards the pending result
    meas_valid = 1'b1; meas_chan = 3'd0; meas_pos = 32'd123;
    @(negedge clk);
    meas_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_pos", position, 0);
    chk("mrst_vel", velocity, 0);
    chk("mrst_chan", out_chan, 0);
    chk("mrst_alert", alert, 0);
    chk("mrst_mask", alert_mask, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_ready", meas_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_no_pending", out_valid, 0);
    xact(0, 500, 0, 0, 0, 0);
    xact(0, 520, 20, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
